serv_regfile_ctrl: RTL and testbench

//   Initiator for the bit-serial 32x32 register file: accepts one parallel request (rs1/rs2 read,

---
 rtl/serv_regfile_ctrl.sv | 137 +++++++++++++
 tb/tb_serv_regfile_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/serv_regfile_ctrl.sv
// Parallel-request initiator for the bit-serial 32x32 register file: issues go, waits for ready,
// deserialises rs1/rs2, optionally streams a full 32-bit rd write, then presents the response.
module serv_regfile_ctrl #(
  parameter int READY_TIMEOUT = 7
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  input  logic [4:0]  i_rd_addr,
  input  logic        i_rd_we,
  input  logic [31:0] i_rd_data,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rs1_data,
  output logic [31:0] o_rs2_data,
  output logic        o_err,
  output logic        o_rf_go,
  input  logic        i_rf_ready,
  output logic [4:0]  o_rf_rs1_addr,
  output logic [4:0]  o_rf_rs2_addr,
  input  logic        i_rf_rs1,
  input  logic        i_rf_rs2,
  output logic        o_rf_rd_en,
  output logic [4:0]  o_rf_rd_addr,
  output logic        o_rf_rd
);

  // state | meaning
  // IDLE  | o_req_ready high, waiting for a request
  // GO    | o_rf_go pulse is on the wire
  // WAIT  | waiting for i_rf_ready, bounded by READY_TIMEOUT
  // READ  | 32 cycles shifting in rs1/rs2, LSB first
  // WRITE | 32 cycles streaming rd data, LSB first
  // RESP  | o_rsp_valid held until i_rsp_ready
  typedef enum logic [2:0] {IDLE, GO, WAIT, READ, WRITE, RESP} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] rd_data;
  logic        rd_we;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      cnt           <= '0;
      rd_data       <= '0;
      rd_we         <= 1'b0;
      o_req_ready   <= 1'b1;
      o_rsp_valid   <= 1'b0;
      o_rs1_data    <= '0;
      o_rs2_data    <= '0;
      o_err         <= 1'b0;
      o_rf_go       <= 1'b0;
      o_rf_rs1_addr <= '0;
      o_rf_rs2_addr <= '0;
      o_rf_rd_en    <= 1'b0;
      o_rf_rd_addr  <= '0;
      o_rf_rd       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            o_req_ready   <= 1'b0;
            o_rf_rs1_addr <= i_rs1_addr;
            o_rf_rs2_addr <= i_rs2_addr;
            o_rf_rd_addr  <= i_rd_addr;
            rd_data       <= i_rd_data;
            // x0 is hardwired; never start a write stream for it
            rd_we         <= i_rd_we && (i_rd_addr != 5'd0);
            o_rs1_data    <= '0;
            o_rs2_data    <= '0;
            o_err         <= 1'b0;
            o_rf_go       <= 1'b1;
            state         <= GO;
          end
        end
        GO: begin
          o_rf_go <= 1'b0;
          cnt     <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (i_rf_ready) begin
            cnt   <= '0;
            state <= READ;
          end else if (cnt == 5'(READY_TIMEOUT - 1)) begin
            o_err       <= 1'b1;
            o_rsp_valid <= 1'b1;
            state       <= RESP;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        READ: begin
          o_rs1_data <= {i_rf_rs1, o_rs1_data[31:1]};
          o_rs2_data <= {i_rf_rs2, o_rs2_data[31:1]};
          cnt        <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            if (rd_we) begin
              o_rf_rd_en <= 1'b1;
              o_rf_rd    <= rd_data[0];
              state      <= WRITE;
            end else begin
              o_rsp_valid <= 1'b1;
              state       <= RESP;
            end
          end
        end
        WRITE: begin
          cnt <= cnt + 5'd1;
          // always a full 32-bit burst so the regfile's bit counter stays aligned
          if (cnt == 5'd31) begin
            o_rf_rd_en  <= 1'b0;
            o_rf_rd     <= 1'b0;
            o_rsp_valid <= 1'b1;
            state       <= RESP;
          end else begin
            o_rf_rd <= rd_data[cnt + 5'd1];
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_err       <= 1'b0;
            o_req_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serv_regfile_ctrl.sv
// Bench for serv_regfile_ctrl: behavioural bit-serial regfile plus a scoreboard of expected
// responses, latencies and write-burst lengths.
module tb_serv_regfile_ctrl;
  localparam int RT = 7;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [4:0]  i_rs1_addr = '0, i_rs2_addr = '0, i_rd_addr = '0;
  logic        i_rd_we = 1'b0;
  logic [31:0] i_rd_data = '0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b0;
  logic [31:0] o_rs1_data, o_rs2_data;
  logic        o_err, o_rf_go;
  logic        i_rf_ready = 1'b0;
  logic [4:0]  o_rf_rs1_addr, o_rf_rs2_addr, o_rf_rd_addr;
  logic        i_rf_rs1 = 1'b0, i_rf_rs2 = 1'b0;
  logic        o_rf_rd_en, o_rf_rd;

  serv_regfile_ctrl #(.READY_TIMEOUT(RT)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr), .i_rd_addr(i_rd_addr),
    .i_rd_we(i_rd_we), .i_rd_data(i_rd_data),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data), .o_err(o_err),
    .o_rf_go(o_rf_go), .i_rf_ready(i_rf_ready),
    .o_rf_rs1_addr(o_rf_rs1_addr), .o_rf_rs2_addr(o_rf_rs2_addr),
    .i_rf_rs1(i_rf_rs1), .i_rf_rs2(i_rf_rs2),
    .o_rf_rd_en(o_rf_rd_en), .o_rf_rd_addr(o_rf_rd_addr), .o_rf_rd(o_rf_rd)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc++;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // behavioural regfile, reacting just after each falling edge
  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];
  int          ready_delay = 2;
  int          cd = 0;
  int          sidx = -1;
  int          widx = 0;
  int          wtotal = 0;
  logic [31:0] wshadow = '0;

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i]     = (i == 0) ? 32'h0 : 32'h1357_9BDF * i;
      ref_mem[i] = mem[i];
    end
    forever begin
      logic was_ready;
      @(negedge i_clk);
      #1;
      if (i_rst) begin
        cd = 0; sidx = -1; widx = 0;
        i_rf_ready = 1'b0; i_rf_rs1 = 1'b0; i_rf_rs2 = 1'b0;
      end else begin
        was_ready  = i_rf_ready;
        i_rf_ready = 1'b0;
        if (was_ready) sidx = 0;
        if (sidx >= 0 && sidx < 32) begin
          i_rf_rs1 = mem[o_rf_rs1_addr][sidx];
          i_rf_rs2 = mem[o_rf_rs2_addr][sidx];
          sidx++;
        end else begin
          i_rf_rs1 = 1'b0; i_rf_rs2 = 1'b0; sidx = -1;
        end
        if (o_rf_go) cd = ready_delay;
        else if (cd > 0) begin
          cd--;
          if (cd == 0) i_rf_ready = 1'b1;
        end
        if (o_rf_rd_en) begin
          wshadow[widx] = o_rf_rd;
          widx++;
          wtotal++;
          if (widx == 32) begin
            if (o_rf_rd_addr != 5'd0) mem[o_rf_rd_addr] = wshadow;
            widx = 0;
          end
        end
      end
    end
  end

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        err;
    int          lat;
    int          nwr;
  } exp_t;
  exp_t sb[$];

  // rdly=0 means the regfile never answers; abort_at>=0 resets during that write cycle
  task automatic do_op(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic we, input logic [31:0] data, input int rdly,
                       input int hold, input int abort_at);
    exp_t e, got_e;
    int   a, n, wbefore;
    bit   tmo, aborted;
    ready_delay = rdly;
    @(negedge i_clk);
    i_rs1_addr = rs1; i_rs2_addr = rs2; i_rd_addr = rd; i_rd_we = we; i_rd_data = data;
    i_req_valid = 1'b1;
    n = 0;
    while (!o_req_ready && n < 50) begin @(negedge i_clk); n++; end
    if (!o_req_ready) begin chk("req_ready_timeout", 32'(o_req_ready), 32'd1); i_req_valid = 1'b0; return; end
    a   = cyc;
    tmo = (rdly == 0);
    e.rs1 = tmo ? 32'h0 : ref_mem[rs1];
    e.rs2 = tmo ? 32'h0 : ref_mem[rs2];
    e.err = tmo;
    e.nwr = (!tmo && we && rd != 5'd0) ? 32 : 0;
    e.lat = tmo ? (2 + RT) : (1 + rdly + 1 + 32 + e.nwr);
    if (e.nwr != 0 && abort_at < 0) ref_mem[rd] = data;
    sb.push_back(e);
    wbefore = wtotal;
    @(negedge i_clk);
    i_req_valid = 1'b0;
    chk("busy_req_ready", 32'(o_req_ready), 32'd0);
    n = 0;
    aborted = 1'b0;
    while (!o_rsp_valid && n < 200) begin
      if (abort_at >= 0 && o_rf_rd_en && (wtotal - wbefore) == abort_at) begin aborted = 1'b1; break; end
      @(negedge i_clk);
      n++;
    end
    if (aborted) begin
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
      chk("abort_rd_en", 32'(o_rf_rd_en), 32'd0);
      chk("abort_rd", 32'(o_rf_rd), 32'd0);
      chk("abort_rsp_valid", 32'(o_rsp_valid), 32'd0);
      chk("abort_req_ready", 32'(o_req_ready), 32'd1);
      chk("abort_rs1", o_rs1_data, 32'h0);
      chk("abort_rd_addr", 32'(o_rf_rd_addr), 32'd0);
      chk("abort_wr_cycles", 32'(wtotal - wbefore), 32'(abort_at));
      void'(sb.pop_front());
      return;
    end
    if (!o_rsp_valid) begin chk("rsp_timeout", 32'(o_rsp_valid), 32'd1); void'(sb.pop_front()); return; end
    chk("rsp_latency", 32'(cyc - a), 32'(e.lat));
    chk("wr_cycles", 32'(wtotal - wbefore), 32'(e.nwr));
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", 32'(o_rsp_valid), 32'd1);
      chk("hold_req_ready", 32'(o_req_ready), 32'd0);
      chk("hold_rs1", o_rs1_data, sb[0].rs1);
      @(negedge i_clk);
    end
    got_e = sb.pop_front();
    chk("rs1_data", o_rs1_data, got_e.rs1);
    chk("rs2_data", o_rs2_data, got_e.rs2);
    chk("err", 32'(o_err), 32'(got_e.err));
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    i_rsp_ready = 1'b0;
    chk("rsp_dropped", 32'(o_rsp_valid), 32'd0);
    chk("idle_req_ready", 32'(o_req_ready), 32'd1);
  endtask

  initial begin
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("rst_req_ready", 32'(o_req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_go", 32'(o_rf_go), 32'd0);
    chk("rst_rd_en", 32'(o_rf_rd_en), 32'd0);
    chk("rst_rs1", o_rs1_data, 32'h0);
    chk("rst_rs2", o_rs2_data, 32'h0);
    i_rst = 1'b0;

    do_op(5'd5, 5'd0, 5'd5, 1'b1, 32'hDEADBEEF, 2, 0, -1);
    do_op(5'd5, 5'd0, 5'd0, 1'b0, 32'h0, 2, 0, -1);
    do_op(5'd0, 5'd0, 5'd0, 1'b1, 32'hFFFFFFFF, 2, 0, -1);
    do_op(5'd0, 5'd5, 5'd0, 1'b0, 32'h0, 2, 0, -1);
    do_op(5'd7, 5'd0, 5'd7, 1'b1, 32'hA5A5A5A5, 3, 0, -1);
    do_op(5'd7, 5'd7, 5'd7, 1'b1, 32'h00001234, 2, 0, -1);
    do_op(5'd7, 5'd0, 5'd0, 1'b0, 32'h0, 4, 0, -1);
    do_op(5'd5, 5'd7, 5'd9, 1'b1, 32'h55AA55AA, 0, 0, -1);
    do_op(5'd9, 5'd5, 5'd0, 1'b0, 32'h0, 2, 0, -1);
    do_op(5'd5, 5'd7, 5'd0, 1'b0, 32'h0, 2, 5, -1);
    do_op(5'd1, 5'd2, 5'd3, 1'b1, 32'hCAFEF00D, 2, 0, 10);
    do_op(5'd3, 5'd0, 5'd3, 1'b1, 32'h0BADF00D, 2, 0, -1);
    do_op(5'd3, 5'd0, 5'd0, 1'b0, 32'h0, 2, 0, -1);
    for (int k = 0; k < 12; k++) begin
      do_op(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), $urandom, $urandom_range(1, 5), $urandom_range(0, 2), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
